// File: rtl/fb_scanout_if.sv
// Scan-out bus bundle: frame-buffer RAM read port (port B) plus the video
// stream toward the PHY.
//   master : driven by fb_scanout (RAM port-B controls, video outputs)
//   slave  : RAM/PHY side (returns fb_doutb, consumes everything else)
interface fb_scanout_if #(
  parameter int unsigned AW  = 8,
  parameter int unsigned BDW = 23
);
  logic           fb_ceb;
  logic           fb_wrb;
  logic [AW:0]    fb_addrb;
  logic [BDW:0]   fb_dinb;
  logic [BDW:0]   fb_doutb;
  logic           vga_hs;
  logic           vga_vs;
  logic           vga_de;
  logic [BDW:0]   vga_rgb;
  logic           frame_start;

  modport master (
    output fb_ceb, fb_wrb, fb_addrb, fb_dinb,
    input  fb_doutb,
    output vga_hs, vga_vs, vga_de, vga_rgb, frame_start
  );

  modport slave (
    input  fb_ceb, fb_wrb, fb_addrb, fb_dinb,
    output fb_doutb,
    input  vga_hs, vga_vs, vga_de, vga_rgb, frame_start
  );
endinterface

// File: rtl/fb_scanout.sv
// Display scan-out engine. Generates raster timing, fetches pixels from a
// FB_W x FB_H frame buffer through RAM port B with 2^SCALE_LOG2 pixel
// replication, and emits an aligned RGB/sync/DE stream, 2 clocks after the
// raster position that produced it.
// Ports:
//   clk, rstn : pixel clock, asynchronous active-low reset
//   en        : scan enable (0 holds the raster at (0,0))
//   fb_base   : frame start address, captured at the first pixel of a frame
//   bus       : RAM port-B controls/read data and video outputs (master side)
module fb_scanout #(
  parameter int unsigned DP         = 512,
  parameter int unsigned DW         = 8,
  parameter int unsigned AW         = $clog2(DP) - 1,
  parameter int unsigned BDW        = 3 * DW - 1,
  parameter int unsigned FB_W       = 32,
  parameter int unsigned FB_H       = 16,
  parameter int unsigned SCALE_LOG2 = 4,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          SYNC_POL   = 1'b0,
  parameter logic [BDW:0] BG        = '0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic [AW:0]   fb_base,
  fb_scanout_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL);
  localparam int unsigned VW      = $clog2(V_TOTAL);
  localparam int unsigned ADW     = AW + 1;
  localparam int unsigned WIN_W   = FB_W << SCALE_LOG2;
  localparam int unsigned WIN_H   = FB_H << SCALE_LOG2;
  localparam int unsigned SCL_MSK = (1 << SCALE_LOG2) - 1;

  logic [HW-1:0]  hcnt;
  logic [VW-1:0]  vcnt;
  logic [ADW-1:0] base_q;
  logic [ADW-1:0] row_q;        // (vcnt >> SCALE_LOG2) * FB_W, kept incrementally
  logic [ADW-1:0] addr_hold_q;

  logic           s1_de, s1_win, s1_hs, s1_vs, s1_fs;

  logic           origin_c, de_c, win_c, hs_c, vs_c, fs_c, ceb_c;
  logic [VW-1:0]  vcnt_inc_c;
  logic [ADW-1:0] frame_base_c, addr_c;

  // Stage 0: raster decode and RAM address for the current position
  always_comb begin
    origin_c     = (hcnt == '0) && (vcnt == '0);
    vcnt_inc_c   = vcnt + VW'(1);
    de_c         = en && (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
    win_c        = de_c && (hcnt < HW'(WIN_W)) && (vcnt < VW'(WIN_H));
    hs_c         = en && (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
    vs_c         = en && (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
    fs_c         = en && origin_c;
    // The first pixel of a frame uses fb_base directly; it is latched that same cycle.
    frame_base_c = origin_c ? fb_base : base_q;
    addr_c       = frame_base_c + row_q + ADW'(hcnt >> SCALE_LOG2);
    // Gated by rstn so the read port stays idle while reset is asserted.
    ceb_c        = rstn && win_c;
  end

  assign bus.fb_ceb   = ceb_c;
  assign bus.fb_addrb = ceb_c ? addr_c : addr_hold_q;
  assign bus.fb_wrb   = 1'b0;
  assign bus.fb_dinb  = '0;

  // Raster counters, base latch and incremental row offset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt        <= '0;
      vcnt        <= '0;
      base_q      <= '0;
      row_q       <= '0;
      addr_hold_q <= '0;
    end else begin
      if (win_c) addr_hold_q <= addr_c;
      if (!en) begin
        hcnt  <= '0;
        vcnt  <= '0;
        row_q <= '0;
      end else begin
        if (origin_c) base_q <= fb_base;
        if (hcnt == HW'(H_TOTAL - 1)) begin
          hcnt <= '0;
          if (vcnt == VW'(V_TOTAL - 1)) begin
            vcnt  <= '0;
            row_q <= '0;
          end else begin
            vcnt <= vcnt_inc_c;
            // Step one frame-buffer row each time a replicated row block ends.
            if ((vcnt_inc_c & VW'(SCL_MSK)) == '0) row_q <= row_q + ADW'(FB_W);
          end
        end else begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  // Stage 1: control flags travel alongside the RAM read
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_de  <= 1'b0;
      s1_win <= 1'b0;
      s1_hs  <= 1'b0;
      s1_vs  <= 1'b0;
      s1_fs  <= 1'b0;
    end else begin
      s1_de  <= de_c;
      s1_win <= win_c;
      s1_hs  <= hs_c;
      s1_vs  <= vs_c;
      s1_fs  <= fs_c;
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.vga_hs      <= ~SYNC_POL;
      bus.vga_vs      <= ~SYNC_POL;
      bus.vga_de      <= 1'b0;
      bus.vga_rgb     <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      bus.vga_hs      <= s1_hs ? SYNC_POL : ~SYNC_POL;
      bus.vga_vs      <= s1_vs ? SYNC_POL : ~SYNC_POL;
      bus.vga_de      <= s1_de;
      bus.vga_rgb     <= s1_de ? (s1_win ? bus.fb_doutb : BG) : '0;
      bus.frame_start <= s1_fs;
    end
  end

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
Display scan-out engine that sits downstream of the 24-bit dual-port frame-buffer RAM and drives its read port (port B). It generates VGA-style raster timing and fetches pixels from a FB_W x FB_H frame buffer, replicating each pixel 2^SCALE_LOG2 times in x and y. It emits a pipelined RGB/sync/DE stream for the video PHY. The window sits at the top-left of the active area; BG colour fills the rest.

Parameters:
DP, 512, frame-buffer depth in pixels
DW, 8, bits per colour channel
AW, $clog2(DP)-1, MSB index of the frame-buffer address
BDW, 3*DW-1, MSB index of the pixel word {R,G,B} = [23:16],[15:8],[7:0]
FB_W, 32, frame-buffer width in pixels (FB_W*FB_H <= DP)
FB_H, 16, frame-buffer height in pixels
SCALE_LOG2, 4, pixel replication shift; window is (FB_W<<S) x (FB_H<<S)
H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48, horizontal timing in clocks
V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33, vertical timing in lines
SYNC_POL, 0, sync active level (0 = active-low)
BG, 24'h000000, colour for active pixels outside the window

Ports:
clk  in  1  pixel clock
rstn  in  1  asynchronous active-low reset
en  in  1  scan enable
fb_base  in  AW+1  frame start address; sampled once per frame
fb_ceb  out  1  RAM port-B clock enable
fb_wrb  out  1  RAM port-B write enable; tied 0
fb_addrb  out  AW+1  RAM port-B address
fb_dinb  out  BDW+1  RAM port-B write data; tied 0
fb_doutb  in  BDW+1  RAM port-B read data; valid 1 cycle after fb_ceb=1
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_de  out  1  data enable
vga_rgb  out  BDW+1  pixel colour
frame_start  out  1  1-cycle pulse, coincident with the output of pixel (0,0)

Behaviour:
- Reset (rstn=0, asynchronous):
  - hcnt=0, vcnt=0, base register=0, pipeline cleared.
  - fb_ceb=0, fb_addrb=0, vga_de=0, vga_rgb=0, frame_start=0.
  - vga_hs and vga_vs held inactive (=~SYNC_POL).
- Counters:
  - hcnt wraps 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - vcnt increments when hcnt wraps, and itself wraps 0..V_TOTAL-1.
  - Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
  - Sync asserted when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vertical sync uses the same rule on vcnt.
- en=0:
  - Counters held at (0,0); fb_ceb=0.
  - Pipeline drains to the inactive state: syncs inactive, de=0, rgb=0.
  - When en returns to 1, the scan restarts at (0,0).
- Base latch:
  - fb_base is captured into the base register in the cycle where en=1 and counters=(0,0).
  - Changes to fb_base mid-frame have no effect until the next frame.
- Window:
  - In window when hcnt < FB_W<<S and vcnt < FB_H<<S, inside the active region.
  - In window: fb_ceb=1 and fb_addrb = base + (vcnt>>S)*FB_W + (hcnt>>S), modulo 2^(AW+1) (wraps).
  - The address is produced with incremental counters; no multiplier.
  - Outside the window: fb_ceb=0 and fb_addrb holds its last value.
- Pipeline, latency exactly 2 clocks:
  - Stage 0: counters are at (h,v) and fb_addrb/fb_ceb are driven from them.
  - Stage 1: fb_doutb is valid; de, sync and in-window flags are delayed one cycle alongside it.
  - Stage 2: output registers load.
- Output rules:
  - vga_rgb = fb_doutb when de and in window.
  - vga_rgb = BG when de and outside the window.
  - vga_rgb = 0 when de=0.
  - hs, vs and de are delayed by the same 2 clocks, so all outputs stay mutually aligned.
- frame_start = 1 for exactly the output cycle of (h,v)=(0,0).
- Reset mid-frame: all state clears immediately; the scan resumes at (0,0) after release with en=1.

Test Plan:
- Reset → release with en=1, fb_base=0, RAM[0]=24'h112233 → fb_addrb=0 and fb_ceb=1 in cycle 0; vga_rgb=24'h112233, vga_de=1 and frame_start=1 exactly 2 clocks later.
- Replication: RAM[1]=24'hAABBCC → vga_rgb=AABBCC for output pixels h=16..31 on lines 0..15; pixel h=512 (outside window) outputs BG with de=1.
- Line/row addressing: at vcnt=16, hcnt=0 → fb_addrb=32; at vcnt=255, hcnt=511 → fb_addrb=511. Check vga_hs low for hcnt 656..751 (delayed 2 clocks) and vga_vs low on lines 490..491.
- Base wrap: fb_base=500 → pixel (hcnt=0, vcnt=16) reads address 20 (532 mod 512). Change fb_base to 100 mid-frame → addresses unchanged until the next (0,0), then pixel (0,0) reads address 100.
- en deassert mid-line → within 2 clocks vga_de=0 and vga_rgb=0, syncs inactive, fb_ceb=0. Reassert en → frame_start pulses 2 clocks later.
- Async reset pulse mid-frame (not clock-aligned) → all outputs take reset values immediately; the next frame starts cleanly at (0,0).
